// File: rtl/dmem_responder_if.sv
// Core-side data-memory bus: address, store data and access mode toward the RAM,
// load data and stall back toward the core.
interface dmem_responder_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_access_mode;
  logic [31:0] mem_rdata;
  logic        stall;

  modport master (
    output mem_addr, mem_wdata, mem_access_mode,
    input  mem_rdata, stall
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_access_mode,
    output mem_rdata, stall
  );
endinterface

// File: rtl/dmem_responder.sv
// Byte-addressable data RAM for anu_core: combinational loads, byte/half/word stores
// with optional wait states that hold the core via stall. State changes on negedge clk.
module dmem_responder #(
  parameter int          ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 0,
  parameter string       INIT_FILE   = ""
) (
  input  logic                clk,
  input  logic                rst_n,
  dmem_responder_if.slave     bus,
  output logic                err,
  output logic [31:0]         store_cnt
);

  localparam int         WORDS  = 2 ** ADDR_WIDTH;
  localparam logic [3:0] WAIT_M1 = 4'(WAIT_CYCLES - 1);

  typedef enum logic {IDLE, BUSY} state_e;

  logic [31:0] ram [WORDS];

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    stall_q, stall_d;
  logic                    err_q, err_d;
  logic [31:0]             store_cnt_q, store_cnt_d;
  logic [ADDR_WIDTH-1:0]   req_widx_q, req_widx_d;
  logic [3:0]              req_be_q, req_be_d;
  logic [31:0]             req_data_q, req_data_d;

  logic [31:0]             off;
  logic [ADDR_WIDTH-1:0]   widx;
  logic [1:0]              lane;
  logic                    in_range, lane_ok, legal, illegal;
  logic [3:0]              cur_be;
  logic [31:0]             cur_data;
  logic                    we;
  logic [ADDR_WIDTH-1:0]   w_idx;
  logic [3:0]              w_be;
  logic [31:0]             w_data;

  // Address decode and the always-live read path.
  always_comb begin
    off      = bus.mem_addr - BASE_ADDR;
    widx     = off[ADDR_WIDTH+1:2];
    lane     = off[1:0];
    in_range = (off[31:ADDR_WIDTH+2] == '0);
    bus.mem_rdata = in_range ? (ram[widx] >> {lane, 3'b000}) : 32'h0;
  end

  // Store legality plus lane steering: data is replicated so the byte enables pick the lane.
  // NOTE: every variable in this block gets a value on every path, so no latch is inferred.
  always_comb begin
    lane_ok  = 1'b0;
    cur_be   = 4'b0000;
    cur_data = bus.mem_wdata;
    unique case (bus.mem_access_mode)
      2'b01: begin
        lane_ok  = 1'b1;
        cur_be   = 4'b0001 << lane;
        cur_data = {4{bus.mem_wdata[7:0]}};
      end
      2'b10: begin
        lane_ok  = ~lane[0];
        cur_be   = lane[1] ? 4'b1100 : 4'b0011;
        cur_data = {2{bus.mem_wdata[15:0]}};
      end
      2'b11: begin
        lane_ok  = (lane == 2'b00);
        cur_be   = 4'b1111;
      end
      default: ;
    endcase
    legal   = in_range && lane_ok;
    illegal = (bus.mem_access_mode != 2'b00) && !legal;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_d     = stall_q;
    err_d       = err_q;
    store_cnt_d = store_cnt_q;
    req_widx_d  = req_widx_q;
    req_be_d    = req_be_q;
    req_data_d  = req_data_q;
    we          = 1'b0;
    w_idx       = widx;
    w_be        = cur_be;
    w_data      = cur_data;
    unique case (state_q)
      IDLE: begin
        if (illegal) begin
          err_d = 1'b1;
        end else if (legal) begin
          if (WAIT_CYCLES == 0) begin
            we          = 1'b1;
            store_cnt_d = store_cnt_q + 32'd1;
          end else begin
            req_widx_d = widx;
            req_be_d   = cur_be;
            req_data_d = cur_data;
            cnt_d      = WAIT_M1;
            stall_d    = 1'b1;
            state_d    = BUSY;
          end
        end
      end
      BUSY: begin
        // The core repeats its stalled store here; only the latched copy is committed.
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          we          = 1'b1;
          w_idx       = req_widx_q;
          w_be        = req_be_q;
          w_data      = req_data_q;
          store_cnt_d = store_cnt_q + 32'd1;
          stall_d     = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      stall_q     <= 1'b0;
      err_q       <= 1'b0;
      store_cnt_q <= '0;
      req_widx_q  <= '0;
      req_be_q    <= '0;
      req_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_q     <= stall_d;
      err_q       <= err_d;
      store_cnt_q <= store_cnt_d;
      req_widx_q  <= req_widx_d;
      req_be_q    <= req_be_d;
      req_data_q  <= req_data_d;
    end
  end

  // NOTE: the RAM array has no reset; contents must survive rst_n and map onto block RAM.
  always_ff @(negedge clk) begin
    if (we && rst_n) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) ram[w_idx][8*b +: 8] <= w_data[8*b +: 8];
      end
    end
  end

  assign bus.stall = stall_q;
  assign err       = err_q;
  assign store_cnt = store_cnt_q;

endmodule
